// File: rtl/line_window_buf_if.sv
// Pixel-in / column-out bundle for line_window_buf.
// The master side feeds pixels and receives columns; the buffer takes the slave side.
interface line_window_buf_if #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned LINES = 2
);
  logic                         in_valid;
  logic                         in_sof;
  logic                         in_eol;
  logic [WIDTH-1:0]             in_data;
  logic                         out_valid;
  logic                         out_sof;
  logic                         out_eol;
  logic [(LINES+1)*WIDTH-1:0]   out_col;
  logic                         out_full;
  logic                         overflow;

  modport master (
    output in_valid, in_sof, in_eol, in_data,
    input  out_valid, out_sof, out_eol, out_col, out_full, overflow
  );

  modport slave (
    input  in_valid, in_sof, in_eol, in_data,
    output out_valid, out_sof, out_eol, out_col, out_full, overflow
  );
endinterface

// File: rtl/line_window_buf.sv
// Multi-line pixel buffer: stores the last LINES lines in read-first RAM banks and emits,
// one cycle after each accepted pixel, the vertical column of LINES+1 pixels at that x.
module line_window_buf #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned LINES = 2
) (
  input logic             clk,
  input logic             rst_n,
  line_window_buf_if.slave bus
);

  localparam int unsigned XW  = $clog2(DEPTH + 1);
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WBW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned LSW = $clog2(LINES + 1);
  localparam logic [XW-1:0]  XMax     = XW'(DEPTH);
  localparam logic [WBW-1:0] WbankMax = WBW'(LINES - 1);
  localparam logic [LSW-1:0] LinesMax = LSW'(LINES);

  logic [XW-1:0]  x_q, x_d, x_eff;
  logic [WBW-1:0] wbank_q, wbank_d, wbank_eff;
  logic [LSW-1:0] lines_q, lines_d, lines_eff;
  logic           overflow_q, overflow_d;
  logic           in_range, ram_en;
  logic [AW-1:0]  addr;
  logic [LINES-1:0] row_en_d;

  // Column-side pipeline registers, captured only on accepted pixels.
  logic             out_valid_q, out_sof_q, out_eol_q, full_q;
  logic [WIDTH-1:0] row0_q;
  logic [LINES-1:0] row_en_q;
  logic [WBW-1:0]   wbank_p_q;

  logic [WIDTH-1:0] rd_data [LINES];
  logic [(LINES+1)*WIDTH-1:0] col;
  logic [WBW-1:0]   bank_sel;

  always_comb begin
    x_eff     = bus.in_sof ? '0 : x_q;
    wbank_eff = bus.in_sof ? '0 : wbank_q;
    lines_eff = bus.in_sof ? '0 : lines_q;
    in_range  = (x_eff != XMax);
    ram_en    = bus.in_valid && in_range;
    addr      = x_eff[AW-1:0];

    for (int k = 1; k <= int'(LINES); k++) begin
      row_en_d[k-1] = in_range && (k <= int'(lines_eff));
    end

    x_d        = x_q;
    wbank_d    = wbank_q;
    lines_d    = lines_q;
    overflow_d = overflow_q;
    if (bus.in_valid) begin
      overflow_d = (bus.in_sof ? 1'b0 : overflow_q) | ~in_range;
      if (bus.in_eol) begin
        x_d     = '0;
        wbank_d = (wbank_eff == WbankMax) ? '0 : wbank_eff + WBW'(1);
        lines_d = (lines_eff == LinesMax) ? lines_eff : lines_eff + LSW'(1);
      end else begin
        x_d     = (x_eff == XMax) ? x_eff : x_eff + XW'(1);
        wbank_d = wbank_eff;
        lines_d = lines_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      wbank_q     <= '0;
      lines_q     <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      full_q      <= 1'b0;
      row0_q      <= '0;
      row_en_q    <= '0;
      wbank_p_q   <= '0;
    end else begin
      x_q         <= x_d;
      wbank_q     <= wbank_d;
      lines_q     <= lines_d;
      overflow_q  <= overflow_d;
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_sof_q <= bus.in_sof;
        out_eol_q <= bus.in_eol;
        full_q    <= in_range && (lines_eff == LinesMax);
        row0_q    <= bus.in_data;
        row_en_q  <= row_en_d;
        wbank_p_q <= wbank_eff;
      end
    end
  end

  // One single-port read-first bank per stored line; only the oldest bank is written.
  for (genvar g = 0; g < int'(LINES); g++) begin : g_bank
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (ram_en) begin
        rd_q <= mem[addr];
        if (wbank_eff == WBW'(g)) begin
          mem[addr] <= bus.in_data;
        end
      end
    end

    assign rd_data[g] = rd_q;
  end

  // Row k comes from bank (wbank + LINES - k) mod LINES; masked rows read as zero.
  always_comb begin
    col               = '0;
    bank_sel          = '0;
    col[0 +: WIDTH]   = row0_q;
    for (int k = 1; k <= int'(LINES); k++) begin
      bank_sel = WBW'((int'(wbank_p_q) + int'(LINES) - k) % int'(LINES));
      if (row_en_q[k-1]) begin
        col[k*WIDTH +: WIDTH] = rd_data[bank_sel];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eol   = out_eol_q;
  assign bus.out_col   = col;
  assign bus.out_full  = full_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_line_window_buf.sv
// Directed and randomized bench for line_window_buf (DEPTH=8, LINES=2) against a
// line-history reference model.
module tb_line_window_buf;
  localparam int unsigned W = 9;
  localparam int unsigned D = 8;
  localparam int unsigned L = 2;
  localparam int unsigned CW = (L + 1) * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  line_window_buf_if #(.WIDTH(W), .LINES(L)) bus ();

  line_window_buf #(.WIDTH(W), .DEPTH(D), .LINES(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [W-1:0] px [D]; } line_t;

  line_t          hist[$];
  line_t          cur;
  int             mx;
  bit             movf;
  logic [CW-1:0]  last_col;
  int             errors = 0;
  int             checks = 0;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model one accepted pixel, drive it, and compare the column one cycle later.
  task automatic pixel(input bit sof, input bit eol, input logic [W-1:0] data);
    logic [CW-1:0] ecol;
    logic          efull;
    if (sof) begin
      hist.delete();
      mx   = 0;
      movf = 0;
    end
    ecol        = '0;
    ecol[W-1:0] = data;
    for (int k = 1; k <= int'(L); k++) begin
      if (mx < int'(D) && k <= hist.size()) ecol[k*W +: W] = hist[k-1].px[mx];
    end
    efull = (mx < int'(D)) && (hist.size() == int'(L));
    if (mx == int'(D)) movf = 1;
    else cur.px[mx] = data;
    if (eol) begin
      hist.push_front(cur);
      if (hist.size() > int'(L)) void'(hist.pop_back());
      mx = 0;
    end else if (mx < int'(D)) begin
      mx++;
    end

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_eol   = eol;
    bus.in_data  = data;
    @(posedge clk);
    #1;
    check("valid", CW'(bus.out_valid), CW'(1'b1));
    check("sof", CW'(bus.out_sof), CW'(sof));
    check("eol", CW'(bus.out_eol), CW'(eol));
    check("col", bus.out_col, ecol);
    check("full", CW'(bus.out_full), CW'(efull));
    check("overflow", CW'(bus.overflow), CW'(movf));
    last_col = ecol;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'($urandom);
    bus.in_eol   = 1'($urandom);
    bus.in_data  = W'($urandom);
    @(posedge clk);
    #1;
    check("gap_valid", CW'(bus.out_valid), '0);
    check("gap_hold", bus.out_col, last_col);
    check("gap_overflow", CW'(bus.overflow), CW'(movf));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_eol   = 1'b0;
    bus.in_data  = '0;
    mx       = 0;
    movf     = 0;
    last_col = '0;

    // Reset held with random input activity: every output must stay zero.
    #1 rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom);
      bus.in_sof   = 1'($urandom);
      bus.in_eol   = 1'($urandom);
      bus.in_data  = W'($urandom);
      @(posedge clk);
      #1;
      check("rst_valid", CW'(bus.out_valid), '0);
      check("rst_col", bus.out_col, '0);
      check("rst_flags", CW'({bus.out_sof, bus.out_eol, bus.out_full, bus.overflow}), '0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;

    // Frame fill then rotation: 5 lines of 4 px, value line*16+x.
    for (int l = 0; l < 5; l++) begin
      for (int x = 0; x < 4; x++) begin
        pixel(l == 0 && x == 0, x == 3, W'(l * 16 + x));
        if (l == 4 && x == 2) check("rotation", bus.out_col, {9'h022, 9'h032, 9'h042});
      end
    end

    // Mid-frame sof: history discarded, then an 8-px line.
    for (int x = 0; x < 8; x++) begin
      pixel(x == 0, x == 7, W'(9'h100 + x));
      if (x == 0) check("midsof_rows", CW'(bus.out_col[CW-1:W]), '0);
    end

    // Overflow: 10-px line, then a normal line still sees its first 8 px.
    for (int x = 0; x < 10; x++) pixel(1'b0, x == 9, W'(9'h050 + x));
    for (int x = 0; x < 4; x++) pixel(1'b0, x == 3, W'(9'h060 + x));
    check("overflow_sticky", CW'(bus.overflow), CW'(1'b1));
    idle();
    idle();
    pixel(1'b1, 1'b0, 9'h1F0);
    check("overflow_clear", CW'(bus.overflow), '0);

    // Random gaps over 3 lines of 6 px with random data.
    for (int l = 0; l < 3; l++) begin
      for (int x = 0; x < 6; x++) begin
        while ($urandom_range(1, 0) == 1) idle();
        pixel(l == 0 && x == 0, x == 5, W'($urandom));
      end
    end

    // One-pixel line (sof+eol) followed by its neighbour below.
    pixel(1'b1, 1'b1, 9'h0A5);
    pixel(1'b0, 1'b1, 9'h15A);
    check("single_px_row1", CW'(bus.out_col[2*W-1:W]), CW'(9'h0A5));
    pixel(1'b0, 1'b0, 9'h0C3);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish within 200000");
    $fatal(1, "timeout");
  end
endmodule
